water_reminder_scheduler: RTL and testbench

Controller that sequences the water-reminder function on top of the time-of-day BCD counter chain. It consumes the one-cycle minute carry from the minutes counter and runs a 2-digit BCD countdown of the configured reminder interval. It raises the alert, handles user acknowledge, alert timeout and snooze, and keeps a saturating BCD count of missed reminders for the display path.

---
 rtl/water_reminder_pkg.sv | 33 +++
 rtl/water_reminder_scheduler_bcd2_down_counter.sv | 33 +++
 rtl/water_reminder_scheduler.sv | 148 ++++++++++++++
 tb/tb_water_reminder_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/water_reminder_pkg.sv
// Shared types and BCD helpers for the water-reminder scheduler.
// Values are 2-digit BCD {tens, ones}; the missed count is a single saturating digit.
package water_reminder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      ALERT  = 2'd2,
      SNOOZE = 2'd3
   } state_t;

   typedef logic [3:0] bcd_digit_t;
   typedef logic [7:0] bcd2_t;

   // Saturates at 00 so a stray decrement can never wrap to 99.
   function automatic bcd2_t bcd2_dec(input bcd2_t v);
      if (v == 8'h00)
         return 8'h00;
      else if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      else
         return {v[7:4], v[3:0] - 4'd1};
   endfunction

   function automatic logic bcd2_valid_nonzero(input bcd2_t v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v != 8'h00);
   endfunction

   function automatic bcd_digit_t bcd_sat_inc(input bcd_digit_t d);
      return (d >= 4'd9) ? 4'd9 : d + 4'd1;
   endfunction

endpackage

// File: rtl/water_reminder_scheduler_bcd2_down_counter.sv
// 2-digit BCD down counter holding the minutes remaining; load beats decrement.
// Zero/one flags are decoded from the registered value for the controller.
module bcd2_down_counter
   import water_reminder_pkg::*;
#(
   parameter bcd2_t RESET_VAL = 8'h30
) (
   input  logic  i_clk,
   input  logic  i_rst_n,
   input  logic  i_load,
   input  bcd2_t i_load_val,
   input  logic  i_dec,
   output bcd2_t o_value,
   output logic  o_zero,
   output logic  o_one
);

   bcd2_t r_value;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_value <= RESET_VAL;
      else if (i_load)
         r_value <= i_load_val;
      else if (i_dec)
         r_value <= bcd2_dec(r_value);
   end

   assign o_value = r_value;
   assign o_zero  = (r_value == 8'h00);
   assign o_one   = (r_value == 8'h01);

endmodule

// File: rtl/water_reminder_scheduler.sv
// Water-reminder controller: BCD interval countdown, alert with timeout, snooze and missed count.
// All outputs registered; every event acts on the edge that samples it.
module water_reminder_scheduler
   import water_reminder_pkg::*;
#(
   parameter bcd2_t DEFAULT_INTERVAL = 8'h30,
   parameter bcd2_t SNOOZE_MIN       = 8'h05,
   parameter int    ALERT_TIMEOUT    = 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_enable,
   input  logic       i_minute_tick,
   input  logic       i_load,
   input  logic [7:0] i_interval_bcd,
   input  logic       i_ack,
   input  logic       i_clear_missed,
   output logic       o_alert,
   output logic [7:0] o_remaining_bcd,
   output logic [3:0] o_missed_bcd,
   output logic [1:0] o_state,
   output logic       o_cfg_err
);

   localparam logic [3:0] TO_LIMIT = 4'(ALERT_TIMEOUT);

   state_t     r_state;
   logic       r_alert;
   logic       r_cfg_err;
   bcd2_t      r_interval;
   bcd_digit_t r_missed;
   logic [3:0] r_to_cnt;

   state_t     w_next_state;
   logic       w_load_ok;
   bcd2_t      w_interval_eff;
   logic       w_cnt_load;
   bcd2_t      w_cnt_load_val;
   logic       w_cnt_dec;
   logic [3:0] w_to_next;
   logic       w_miss_inc;
   bcd2_t      w_remaining;
   logic       w_zero;
   logic       w_one;

   assign w_load_ok      = i_load && bcd2_valid_nonzero(i_interval_bcd);
   // A valid load on the same edge as a reload must take effect immediately.
   assign w_interval_eff = w_load_ok ? i_interval_bcd : r_interval;

   bcd2_down_counter #(.RESET_VAL(DEFAULT_INTERVAL)) u_remaining (
      .i_clk      (i_clk),
      .i_rst_n    (i_reset),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_load_val),
      .i_dec      (w_cnt_dec),
      .o_value    (w_remaining),
      .o_zero     (w_zero),
      .o_one      (w_one)
   );

   always_comb begin
      w_next_state   = r_state;
      w_cnt_load     = 1'b0;
      w_cnt_load_val = w_interval_eff;
      w_cnt_dec      = 1'b0;
      w_to_next      = r_to_cnt;
      w_miss_inc     = 1'b0;
      if (!i_enable) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               w_next_state = COUNT;
               w_cnt_load   = 1'b1;
            end
            COUNT: begin
               if (w_load_ok) begin
                  w_cnt_load = 1'b1;
               end else if (i_minute_tick && !w_zero) begin
                  w_cnt_dec = 1'b1;
                  if (w_one) begin
                     w_next_state = ALERT;
                     w_to_next    = 4'd0;
                  end
               end
            end
            ALERT: begin
               if (i_ack) begin
                  w_next_state = COUNT;
                  w_cnt_load   = 1'b1;
               end else if (i_minute_tick) begin
                  if (r_to_cnt + 4'd1 >= TO_LIMIT) begin
                     w_next_state   = SNOOZE;
                     w_cnt_load     = 1'b1;
                     w_cnt_load_val = SNOOZE_MIN;
                     w_to_next      = 4'd0;
                     w_miss_inc     = 1'b1;
                  end else begin
                     w_to_next = r_to_cnt + 4'd1;
                  end
               end
            end
            SNOOZE: begin
               if (i_ack) begin
                  w_next_state = COUNT;
                  w_cnt_load   = 1'b1;
               end else if (i_minute_tick && !w_zero) begin
                  w_cnt_dec = 1'b1;
                  if (w_one) begin
                     w_next_state = ALERT;
                     w_to_next    = 4'd0;
                  end
               end
            end
            default: w_next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= IDLE;
         r_alert    <= 1'b0;
         r_cfg_err  <= 1'b0;
         r_interval <= DEFAULT_INTERVAL;
         r_missed   <= 4'd0;
         r_to_cnt   <= 4'd0;
      end else begin
         r_state   <= w_next_state;
         r_alert   <= (w_next_state == ALERT);
         r_cfg_err <= i_load && !w_load_ok;
         r_to_cnt  <= w_to_next;
         if (w_load_ok)
            r_interval <= i_interval_bcd;
         if (i_clear_missed)
            r_missed <= 4'd0;
         else if (w_miss_inc)
            r_missed <= bcd_sat_inc(r_missed);
      end
   end

   assign o_alert         = r_alert;
   assign o_remaining_bcd = w_remaining;
   assign o_missed_bcd    = r_missed;
   assign o_state         = r_state;
   assign o_cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_water_reminder_scheduler.sv
// Directed scoreboard bench: each stimulus step queues the expected post-edge outputs,
// a monitor pops one entry per clock and compares.
module tb_water_reminder_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       tick = 1'b0;
   logic       ld = 1'b0;
   logic [7:0] ival = 8'h00;
   logic       ack = 1'b0;
   logic       clr = 1'b0;
   logic       alert;
   logic [7:0] rem;
   logic [3:0] missed;
   logic [1:0] state;
   logic       cfg_err;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string      nm;
      logic [1:0] st;
      logic [7:0] rem;
      logic [3:0] mis;
      logic       ce;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   water_reminder_scheduler dut (
      .i_clk          (clk),
      .i_reset        (rst_n),
      .i_enable       (en),
      .i_minute_tick  (tick),
      .i_load         (ld),
      .i_interval_bcd (ival),
      .i_ack          (ack),
      .i_clear_missed (clr),
      .o_alert        (alert),
      .o_remaining_bcd(rem),
      .o_missed_bcd   (missed),
      .o_state        (state),
      .o_cfg_err      (cfg_err)
   );

   task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
      end
   endtask

   // Monitor: compare the registered outputs just after each active edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk(e.nm, "state",   8'(state),   8'(e.st));
         chk(e.nm, "alert",   8'(alert),   8'(e.st == 2'd2));
         chk(e.nm, "rem",     rem,         e.rem);
         chk(e.nm, "missed",  8'(missed),  8'(e.mis));
         chk(e.nm, "cfg_err", 8'(cfg_err), 8'(e.ce));
      end
   end

   task automatic step(input logic t, input logic l, input logic [7:0] v, input logic a,
                       input logic c, input logic [1:0] es, input logic [7:0] er,
                       input logic [3:0] em, input logic ec, input string nm);
      exp_t e;
      @(negedge clk);
      tick = t; ld = l; ival = v; ack = a; clr = c;
      e.nm = nm; e.st = es; e.rem = er; e.mis = em; e.ce = ec;
      q.push_back(e);
      @(posedge clk);
      #2;
      tick = 1'b0; ld = 1'b0; ack = 1'b0; clr = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #2;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain actual=%0d pending required=0", q.size());
         q.delete();
      end
   endtask

   initial begin
      logic [3:0] m_exp;
      // Reset state
      #12;
      chk("reset", "state",   8'(state),   8'h00);
      chk("reset", "alert",   8'(alert),   8'h00);
      chk("reset", "rem",     rem,         8'h30);
      chk("reset", "missed",  8'(missed),  8'h00);
      chk("reset", "cfg_err", 8'(cfg_err), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: countdown
      en = 1'b1;
      step(0, 0, 8'h00, 0, 0, 2'd1, 8'h30, 4'd0, 0, "t1_arm");
      step(0, 1, 8'h03, 0, 0, 2'd1, 8'h03, 4'd0, 0, "t1_load03");
      step(1, 0, 8'h00, 0, 0, 2'd1, 8'h02, 4'd0, 0, "t1_tick1");
      step(1, 0, 8'h00, 0, 0, 2'd1, 8'h01, 4'd0, 0, "t1_tick2");
      step(1, 0, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 0, "t1_tick3_alert");
      step(0, 0, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 0, "t1_alert_hold");

      // 2: ack
      step(0, 0, 8'h00, 1, 0, 2'd1, 8'h03, 4'd0, 0, "t2_ack");
      step(0, 0, 8'h00, 1, 0, 2'd1, 8'h03, 4'd0, 0, "t2_ack_in_count");

      // 3: timeout, snooze, saturation, clear
      step(0, 1, 8'h01, 0, 0, 2'd1, 8'h01, 4'd0, 0, "t3_load01");
      step(1, 0, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 0, "t3_first_alert");
      m_exp = 4'd0;
      for (int k = 1; k <= 10; k++) begin
         step(1, 0, 8'h00, 0, 0, 2'd2, 8'h00, m_exp, 0, "t3_to1");
         m_exp = (k > 9) ? 4'd9 : 4'(k);
         step(1, 0, 8'h00, 0, 0, 2'd3, 8'h05, m_exp, 0, "t3_snooze");
         for (int r = 4; r >= 1; r--)
            step(1, 0, 8'h00, 0, 0, 2'd3, 8'(r), m_exp, 0, "t3_snooze_dec");
         step(1, 0, 8'h00, 0, 0, 2'd2, 8'h00, m_exp, 0, "t3_realert");
      end
      step(0, 0, 8'h00, 0, 1, 2'd2, 8'h00, 4'd0, 0, "t3_clear");
      step(1, 0, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 0, "t3_to1b");
      step(1, 0, 8'h00, 0, 1, 2'd3, 8'h05, 4'd0, 0, "t3_clear_vs_inc");
      step(0, 0, 8'h00, 1, 0, 2'd1, 8'h01, 4'd0, 0, "t3_ack_snooze");

      // 4: borrow and validation
      step(0, 1, 8'h10, 0, 0, 2'd1, 8'h10, 4'd0, 0, "t4_load10");
      step(1, 0, 8'h00, 0, 0, 2'd1, 8'h09, 4'd0, 0, "t4_borrow");
      step(0, 1, 8'h1A, 0, 0, 2'd1, 8'h09, 4'd0, 1, "t4_bad1A");
      step(0, 1, 8'h00, 0, 0, 2'd1, 8'h09, 4'd0, 1, "t4_bad00");
      step(0, 0, 8'h00, 0, 0, 2'd1, 8'h09, 4'd0, 0, "t4_err_clears");
      for (int v = 8; v >= 1; v--)
         step(1, 0, 8'h00, 0, 0, 2'd1, 8'(v), 4'd0, 0, "t4_dec");
      step(1, 0, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 0, "t4_alert");
      step(0, 0, 8'h00, 1, 0, 2'd1, 8'h10, 4'd0, 0, "t4_interval_kept");

      // 5: priority
      step(0, 1, 8'h01, 0, 0, 2'd1, 8'h01, 4'd0, 0, "t5_load01");
      step(1, 0, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 0, "t5_alert");
      step(1, 0, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 0, "t5_to1");
      step(1, 0, 8'h00, 1, 0, 2'd1, 8'h01, 4'd0, 0, "t5_ack_tick");
      step(1, 0, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 0, "t5_alert2");
      step(1, 0, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 0, "t5_to_fresh");
      step(0, 1, 8'h02, 1, 0, 2'd1, 8'h02, 4'd0, 0, "t5_ack_load");
      step(1, 0, 8'h00, 0, 0, 2'd1, 8'h01, 4'd0, 0, "t5_dec");
      step(1, 0, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 0, "t5_alert3");
      en = 1'b0;
      step(0, 0, 8'h00, 1, 0, 2'd0, 8'h00, 4'd0, 0, "t5_disable_ack");
      en = 1'b1;
      step(0, 0, 8'h00, 0, 0, 2'd1, 8'h02, 4'd0, 0, "t5_rearm");
      en = 1'b0;
      step(0, 0, 8'h00, 0, 0, 2'd0, 8'h02, 4'd0, 0, "t5_idle");
      en = 1'b1;
      step(0, 1, 8'h04, 0, 0, 2'd1, 8'h04, 4'd0, 0, "t5_arm_load");

      // 6: async reset mid-alert
      step(0, 1, 8'h01, 0, 0, 2'd1, 8'h01, 4'd0, 0, "t6_load01");
      step(1, 0, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 0, "t6_alert");
      step(1, 0, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 0, "t6_to1");
      step(1, 0, 8'h00, 0, 0, 2'd3, 8'h05, 4'd1, 0, "t6_snooze");
      for (int r = 4; r >= 1; r--)
         step(1, 0, 8'h00, 0, 0, 2'd3, 8'(r), 4'd1, 0, "t6_dec");
      step(1, 0, 8'h00, 0, 0, 2'd2, 8'h00, 4'd1, 0, "t6_alert2");
      drain();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_async", "alert",  8'(alert),  8'h00);
      chk("t6_async", "state",  8'(state),  8'h00);
      chk("t6_async", "rem",    rem,        8'h30);
      chk("t6_async", "missed", 8'(missed), 8'h00);
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 8'h00, 0, 0, 2'd0, 8'h30, 4'd0, 0, "t6_released");
      en = 1'b1;
      step(0, 0, 8'h00, 0, 0, 2'd1, 8'h30, 4'd0, 0, "t6_default_interval");
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
